// File: rtl/cpu_lsu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_lsu_pkg
//   Shared types and helpers for the load/store unit.
//   - lsu_op_t       : decoded view of the 4-bit op {write, unsigned, size}
//   - SIZE_*         : access size encodings
//   - pend_entry_t   : what the LSU remembers about an outstanding load
//   - lsu_misaligned : alignment check for an access
//   - lsu_load_align : lane shift plus zero/sign extension of a load word
// ----------------------------------------------------------------------------
package cpu_lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Width of the slot field carried in the dcache tag.
   localparam int SLOT_W = 4;
   localparam int TAG_W  = 9;

   typedef struct packed {
      logic       write;
      logic       is_unsigned;
      logic [1:0] size;
   } lsu_op_t;

   typedef struct packed {
      logic [4:0] dest;
      logic [1:0] size;
      logic       is_unsigned;
      logic [1:0] offset;
   } pend_entry_t;

   // Size 3 is not a legal encoding; it is treated as a word everywhere so
   // that it can never slip through as an unaligned wide access.
   function automatic logic lsu_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
      return ((size == SIZE_HALF) && offset[0]) ||
             (size[1] && (offset != 2'b00));
   endfunction

   function automatic logic [31:0] lsu_load_align(input logic [31:0] rdata,
                                                  input pend_entry_t entry);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = rdata >> {entry.offset, 3'b000};
      case (entry.size)
         SIZE_BYTE: result = entry.is_unsigned ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: result = entry.is_unsigned ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
         default:   result = shifted;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/cpu_lsu_if.sv
// ----------------------------------------------------------------------------
// cpu_lsu_if
//   Request/response bus between the load/store unit and cpu_dcache.
//   master : LSU side   (drives request, write, address, burst, wstrb, wdata)
//   slave  : dcache side (drives ready, rvalid, rdata, rtag)
//   For loads, wdata[8:0] carries the tag {slot, dest} that the dcache echoes
//   back on rtag with the response.
// ----------------------------------------------------------------------------
interface cpu_lsu_if;

   logic                           cpu_dcache_request;
   logic                           cpu_dcache_ready;
   logic                           cpu_dcache_write;
   logic [31:0]                    cpu_dcache_address;
   logic                           cpu_dcache_burst;
   logic [3:0]                     cpu_dcache_wstrb;
   logic [31:0]                    cpu_dcache_wdata;
   logic                           cpu_dcache_rvalid;
   logic [31:0]                    cpu_dcache_rdata;
   logic [cpu_lsu_pkg::TAG_W-1:0]  cpu_dcache_rtag;

   modport master (
      output cpu_dcache_request,
      output cpu_dcache_write,
      output cpu_dcache_address,
      output cpu_dcache_burst,
      output cpu_dcache_wstrb,
      output cpu_dcache_wdata,
      input  cpu_dcache_ready,
      input  cpu_dcache_rvalid,
      input  cpu_dcache_rdata,
      input  cpu_dcache_rtag
   );

   modport slave (
      input  cpu_dcache_request,
      input  cpu_dcache_write,
      input  cpu_dcache_address,
      input  cpu_dcache_burst,
      input  cpu_dcache_wstrb,
      input  cpu_dcache_wdata,
      output cpu_dcache_ready,
      output cpu_dcache_rvalid,
      output cpu_dcache_rdata,
      output cpu_dcache_rtag
   );

endinterface

// File: rtl/cpu_lsu_pend_fifo.sv
// ----------------------------------------------------------------------------
// cpu_lsu_pend_fifo
//   In-order FIFO of outstanding loads.
//   clock, reset        : clock, asynchronous active-low reset
//   push, push_data     : enqueue an entry (ignored when full)
//   pop                 : dequeue the head (ignored when empty)
//   head                : current head entry (combinational read)
//   full, empty, count  : occupancy
//   wr_slot, rd_slot    : write / head slot index, used as the load tag
//   DEPTH must be a power of two (2..16) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module cpu_lsu_pend_fifo
   import cpu_lsu_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  pend_entry_t       push_data,
   input  logic              pop,
   output pend_entry_t       head,
   output logic              full,
   output logic              empty,
   output logic [4:0]        count,
   output logic [SLOT_W-1:0] wr_slot,
   output logic [SLOT_W-1:0] rd_slot
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [4:0]       count_reg;
   logic             do_push;
   logic             do_pop;
   pend_entry_t      entries [DEPTH];

   assign full    = (count_reg == 5'(DEPTH));
   assign empty   = (count_reg == 5'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Each entry is its own register bank; the head is needed in the same
   // cycle as the response, so the read side is an asynchronous mux.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         pend_entry_t entry_reg;
         always_ff @(posedge clock) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
               entry_reg <= push_data;
            end
         end
         assign entries[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= 5'd0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 5'd1;
            2'b01:   count_reg <= count_reg - 5'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head    = entries[rd_ptr_reg];
   assign count   = count_reg;
   assign wr_slot = SLOT_W'(wr_ptr_reg);
   assign rd_slot = SLOT_W'(rd_ptr_reg);

endmodule

// File: rtl/cpu_lsu.sv
// ----------------------------------------------------------------------------
// cpu_lsu
//   Load/store unit between the execute stage and cpu_dcache.
//   clock, reset          : clock, asynchronous active-low reset
//   lsu_valid/lsu_ready   : op handshake from execute
//   lsu_op/addr/wdata/dest: op {write, unsigned, size}, byte address,
//                           right-justified store data, load destination
//   dc (cpu_lsu_if.master): registered dcache request and load response
//   wb_valid/dest/data    : one-cycle load writeback
//   exc_valid/exc_addr    : one-cycle misaligned-access report
//   pend_count            : loads outstanding (queued or issued)
// ----------------------------------------------------------------------------
module cpu_lsu
   import cpu_lsu_pkg::*;
#(
   parameter int PEND_DEPTH = 4
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [3:0]  lsu_op,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [4:0]  lsu_dest,
   cpu_lsu_if.master   dc,
   output logic        wb_valid,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        exc_valid,
   output logic [31:0] exc_addr,
   output logic [4:0]  pend_count
);

   lsu_op_t           op;
   logic              is_load;
   logic              misaligned;
   logic              accept;
   logic              issue;
   logic              resp_hit;
   logic [3:0]        fmt_wstrb;
   logic [31:0]       fmt_wdata;
   pend_entry_t       push_entry;
   pend_entry_t       head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [4:0]        fifo_count;
   logic [SLOT_W-1:0] wr_slot;
   logic [SLOT_W-1:0] rd_slot;

   logic              req_reg;
   logic              req_write_reg;
   logic [31:0]       req_addr_reg;
   logic [3:0]        req_wstrb_reg;
   logic [31:0]       req_wdata_reg;
   logic              wb_valid_reg;
   logic [4:0]        wb_dest_reg;
   logic [31:0]       wb_data_reg;
   logic              exc_valid_reg;
   logic [31:0]       exc_addr_reg;

   assign op         = lsu_op_t'(lsu_op);
   assign is_load    = !op.write;
   assign misaligned = lsu_misaligned(op.size, lsu_addr[1:0]);

   // The full check deliberately ignores a same-cycle pop so the ready path
   // does not depend on the dcache response.
   assign lsu_ready = (!req_reg || dc.cpu_dcache_ready) && !(is_load && fifo_full);
   assign accept    = lsu_valid && lsu_ready;
   assign issue     = accept && !misaligned;

   always_comb begin
      fmt_wstrb = 4'b0000;
      fmt_wdata = lsu_wdata;
      if (is_load) begin
         fmt_wdata = {23'h0, wr_slot, lsu_dest};
      end else begin
         case (op.size)
            SIZE_BYTE: begin
               fmt_wdata = {4{lsu_wdata[7:0]}};
               fmt_wstrb = 4'b0001 << lsu_addr[1:0];
            end
            SIZE_HALF: begin
               fmt_wdata = {2{lsu_wdata[15:0]}};
               fmt_wstrb = 4'b0011 << lsu_addr[1:0];
            end
            default: begin
               fmt_wdata = lsu_wdata;
               fmt_wstrb = 4'b1111;
            end
         endcase
      end
   end

   assign push_entry = '{dest:        lsu_dest,
                         size:        op.size,
                         is_unsigned: op.is_unsigned,
                         offset:      lsu_addr[1:0]};

   // The whole echoed tag is compared, so a response with a corrupted
   // destination is dropped instead of writing the wrong register.
   assign resp_hit = dc.cpu_dcache_rvalid && !fifo_empty &&
                     (dc.cpu_dcache_rtag == {rd_slot, head.dest});

   cpu_lsu_pend_fifo #(
      .DEPTH (PEND_DEPTH)
   ) u_pend_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (issue && is_load),
      .push_data (push_entry),
      .pop       (resp_hit),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .wr_slot   (wr_slot),
      .rd_slot   (rd_slot)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_reg       <= 1'b0;
         req_write_reg <= 1'b0;
         req_addr_reg  <= 32'h0;
         req_wstrb_reg <= 4'h0;
         req_wdata_reg <= 32'h0;
         wb_valid_reg  <= 1'b0;
         wb_dest_reg   <= 5'h0;
         wb_data_reg   <= 32'h0;
         exc_valid_reg <= 1'b0;
         exc_addr_reg  <= 32'h0;
      end else begin
         // An accepted misaligned op frees the request slot without issuing.
         if (accept) begin
            req_reg <= !misaligned;
         end else if (dc.cpu_dcache_ready) begin
            req_reg <= 1'b0;
         end
         if (issue) begin
            req_write_reg <= op.write;
            req_addr_reg  <= {lsu_addr[31:2], 2'b00};
            req_wstrb_reg <= fmt_wstrb;
            req_wdata_reg <= fmt_wdata;
         end

         exc_valid_reg <= accept && misaligned;
         if (accept && misaligned) begin
            exc_addr_reg <= lsu_addr;
         end

         wb_valid_reg <= resp_hit;
         if (resp_hit) begin
            wb_dest_reg <= head.dest;
            wb_data_reg <= lsu_load_align(dc.cpu_dcache_rdata, head);
         end
      end
   end

   assign dc.cpu_dcache_request = req_reg;
   assign dc.cpu_dcache_write   = req_write_reg;
   assign dc.cpu_dcache_address = req_addr_reg;
   assign dc.cpu_dcache_burst   = 1'b0;
   assign dc.cpu_dcache_wstrb   = req_wstrb_reg;
   assign dc.cpu_dcache_wdata   = req_wdata_reg;

   assign wb_valid   = wb_valid_reg;
   assign wb_dest    = wb_dest_reg;
   assign wb_data    = wb_data_reg;
   assign exc_valid  = exc_valid_reg;
   assign exc_addr   = exc_addr_reg;
   assign pend_count = fifo_count;

   a_resp_with_pending: assert property (@(posedge clock) disable iff (!reset)
      dc.cpu_dcache_rvalid |-> !fifo_empty)
      else $error("cpu_lsu: load response with no outstanding load");

   a_resp_slot_order: assert property (@(posedge clock) disable iff (!reset)
      (dc.cpu_dcache_rvalid && !fifo_empty) |->
         (dc.cpu_dcache_rtag[TAG_W-1:5] == rd_slot))
      else $error("cpu_lsu: load response slot differs from oldest load");

endmodule

// File: tb/tb_cpu_lsu.sv
module tb_cpu_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [3:0]  lsu_op;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [4:0]  lsu_dest;
   logic        wb_valid;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [31:0] exc_addr;
   logic [4:0]  pend_count;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   cpu_lsu_if dc();

   cpu_lsu #(.PEND_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_op     (lsu_op),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_dest   (lsu_dest),
      .dc         (dc),
      .wb_valid   (wb_valid),
      .wb_dest    (wb_dest),
      .wb_data    (wb_data),
      .exc_valid  (exc_valid),
      .exc_addr   (exc_addr),
      .pend_count (pend_count)
   );

   // dcache model: loads taken at a clock edge are answered, in order, in the
   // following cycle(s) while resp_en is high.
   logic        resp_en     = 1'b0;
   logic        tagged_data = 1'b0;
   logic [31:0] rdata_val   = 32'h0;
   logic [8:0]  tag_q [$];

   always @(posedge clock) begin
      logic       took;
      logic [8:0] t;
      took = dc.cpu_dcache_request && dc.cpu_dcache_ready && !dc.cpu_dcache_write;
      t    = dc.cpu_dcache_wdata[8:0];
      #1;
      if (took) tag_q.push_back(t);
      if (!reset) begin
         tag_q.delete();
         dc.cpu_dcache_rvalid = 1'b0;
         dc.cpu_dcache_rtag   = 9'h0;
         dc.cpu_dcache_rdata  = 32'h0;
      end else if (resp_en && tag_q.size() > 0) begin
         t = tag_q.pop_front();
         dc.cpu_dcache_rvalid = 1'b1;
         dc.cpu_dcache_rtag   = t;
         dc.cpu_dcache_rdata  = tagged_data ? (32'hC0DE0000 | {27'h0, t[4:0]}) : rdata_val;
      end else begin
         dc.cpu_dcache_rvalid = 1'b0;
         dc.cpu_dcache_rtag   = 9'h0;
         dc.cpu_dcache_rdata  = 32'h0;
      end
   end

   // Load vectors against rdata 0x80FF7F01.
   logic [3:0]  ld_op   [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0010};
   logic [31:0] ld_addr [4] = '{32'h202, 32'h202, 32'h202, 32'h200};
   logic [4:0]  ld_dest [4] = '{5'd1, 5'd2, 5'd3, 5'd7};
   logic [31:0] ld_exp  [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h80FF7F01};

   // Presents one op from posedge+1, waits (bounded) for acceptance and
   // returns at posedge+1 of the cycle after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] dest);
      bit ok;
      ok = 1'b0;
      lsu_valid = 1'b1; lsu_op = op; lsu_addr = addr; lsu_wdata = wd; lsu_dest = dest;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (lsu_ready) begin ok = 1'b1; break; end
         @(posedge clock); #1;
      end
      checks++;
      if (!ok) begin
         $display("FAIL issue_accept addr=%h: lsu_ready got 0 for 20 cycles, need 1", addr);
         errors++;
      end
      @(posedge clock); #1;
      lsu_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clock); @(posedge clock); #1;
      checks++;
      if (dc.cpu_dcache_request !== 1'b0 || dc.cpu_dcache_address !== 32'h0 || dc.cpu_dcache_wstrb !== 4'h0) begin
         $display("FAIL reset_request: req=%b addr=%h wstrb=%h, need 0/0/0",
                  dc.cpu_dcache_request, dc.cpu_dcache_address, dc.cpu_dcache_wstrb);
         errors++;
      end
      checks++;
      if (wb_valid !== 1'b0 || exc_valid !== 1'b0) begin
         $display("FAIL reset_pulses: wb_valid=%b exc_valid=%b, need 0/0", wb_valid, exc_valid);
         errors++;
      end
      checks++;
      if (pend_count !== 5'd0) begin
         $display("FAIL reset_pend: pend_count=%0d, need 0", pend_count); errors++;
      end
      checks++;
      if (lsu_ready !== 1'b1) begin
         $display("FAIL reset_ready: lsu_ready=%b, need 1", lsu_ready); errors++;
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      $display("test_reset done");
   endtask

   task automatic test_store_word();
      issue(4'b1010, 32'h100, 32'h12345678, 5'd0);
      @(negedge clock);
      checks++;
      if (dc.cpu_dcache_request !== 1'b1 || dc.cpu_dcache_write !== 1'b1 || dc.cpu_dcache_burst !== 1'b0) begin
         $display("FAIL sw_request: req=%b write=%b burst=%b, need 1/1/0",
                  dc.cpu_dcache_request, dc.cpu_dcache_write, dc.cpu_dcache_burst);
         errors++;
      end
      checks++;
      if (dc.cpu_dcache_wstrb !== 4'hF || dc.cpu_dcache_wdata !== 32'h12345678 || dc.cpu_dcache_address !== 32'h100) begin
         $display("FAIL sw_fields: wstrb=%h wdata=%h addr=%h, need F/12345678/00000100",
                  dc.cpu_dcache_wstrb, dc.cpu_dcache_wdata, dc.cpu_dcache_address);
         errors++;
      end
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (dc.cpu_dcache_request !== 1'b0 || wb_valid !== 1'b0 || pend_count !== 5'd0) begin
         $display("FAIL sw_after: req=%b wb_valid=%b pend=%0d, need 0/0/0",
                  dc.cpu_dcache_request, wb_valid, pend_count);
         errors++;
      end
      @(posedge clock); #1;
      $display("test_store_word done");
   endtask

   task automatic test_store_byte();
      issue(4'b1000, 32'h203, 32'h000000AB, 5'd0);
      @(negedge clock);
      checks++;
      if (dc.cpu_dcache_wstrb !== 4'h8 || dc.cpu_dcache_wdata !== 32'hABABABAB || dc.cpu_dcache_address !== 32'h200) begin
         $display("FAIL sb_fields: wstrb=%h wdata=%h addr=%h, need 8/ABABABAB/00000200",
                  dc.cpu_dcache_wstrb, dc.cpu_dcache_wdata, dc.cpu_dcache_address);
         errors++;
      end
      @(posedge clock); #1;
      $display("test_store_byte done");
   endtask

   task automatic test_loads();
      rdata_val = 32'h80FF7F01;
      @(negedge clock);
      resp_en = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
         issue(ld_op[i], ld_addr[i], 32'h0, ld_dest[i]);
         @(negedge clock);
         checks++;
         if (dc.cpu_dcache_request !== 1'b1 || dc.cpu_dcache_write !== 1'b0 || dc.cpu_dcache_wstrb !== 4'h0 ||
             dc.cpu_dcache_wdata[8:0] !== {4'(i), ld_dest[i]} || pend_count !== 5'd1) begin
            $display("FAIL load%0d_request: req=%b write=%b wstrb=%h tag=%h pend=%0d, need 1/0/0/%h/1", i,
                     dc.cpu_dcache_request, dc.cpu_dcache_write, dc.cpu_dcache_wstrb,
                     dc.cpu_dcache_wdata[8:0], pend_count, {4'(i), ld_dest[i]});
            errors++;
         end
         @(posedge clock); #1;
         @(negedge clock);
         checks++;
         if (wb_valid !== 1'b0) begin
            $display("FAIL load%0d_early_wb: wb_valid=%b at N+2, need 0", i, wb_valid); errors++;
         end
         @(posedge clock); #1;
         @(negedge clock);
         checks++;
         if (wb_valid !== 1'b1 || wb_dest !== ld_dest[i] || wb_data !== ld_exp[i] || pend_count !== 5'd0) begin
            $display("FAIL load%0d_wb: valid=%b dest=%0d data=%h pend=%0d, need 1/%0d/%h/0", i,
                     wb_valid, wb_dest, wb_data, pend_count, ld_dest[i], ld_exp[i]);
            errors++;
         end
         @(posedge clock); #1;
         $display("load %0d op=%b addr=%h -> dest=%0d data=%h", i, ld_op[i], ld_addr[i], wb_dest, wb_data);
      end
   endtask

   task automatic test_misaligned();
      issue(4'b0001, 32'h101, 32'h0, 5'd4);
      @(negedge clock);
      checks++;
      if (exc_valid !== 1'b1 || exc_addr !== 32'h101) begin
         $display("FAIL misaligned_exc: exc_valid=%b exc_addr=%h, need 1/00000101", exc_valid, exc_addr);
         errors++;
      end
      checks++;
      if (dc.cpu_dcache_request !== 1'b0 || pend_count !== 5'd0) begin
         $display("FAIL misaligned_noissue: req=%b pend=%0d, need 0/0", dc.cpu_dcache_request, pend_count);
         errors++;
      end
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (exc_valid !== 1'b0) begin
         $display("FAIL misaligned_pulse: exc_valid=%b one cycle later, need 0", exc_valid); errors++;
      end
      @(posedge clock); #1;
      $display("test_misaligned done");
   endtask

   task automatic test_back_to_back();
      int  wb_seen;
      bit  saw5;
      bit  take;
      @(negedge clock);
      resp_en = 1'b0;
      tagged_data = 1'b1;
      @(posedge clock); #1;
      lsu_valid = 1'b1;
      lsu_op    = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         lsu_addr = 32'h300 + 32'(4 * i);
         lsu_dest = 5'(10 + i);
         @(negedge clock);
         checks++;
         if (lsu_ready !== (i < 4)) begin
            $display("FAIL b2b_ready%0d: lsu_ready=%b, need %b", i, lsu_ready, (i < 4));
            errors++;
         end
         if (i < 4) begin @(posedge clock); #1; end
      end
      checks++;
      if (pend_count !== 5'd4) begin
         $display("FAIL b2b_pend_full: pend_count=%0d, need 4", pend_count); errors++;
      end
      resp_en = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (dc.cpu_dcache_rvalid !== 1'b1 || lsu_ready !== 1'b0) begin
         $display("FAIL b2b_full_with_pop: rvalid=%b lsu_ready=%b, need 1/0", dc.cpu_dcache_rvalid, lsu_ready);
         errors++;
      end
      wb_seen = 0;
      saw5    = 1'b0;
      for (int c = 0; c < 40 && wb_seen < 5; c++) begin
         if (wb_valid === 1'b1) begin
            checks++;
            if (wb_dest !== 5'(10 + wb_seen) || wb_data !== (32'hC0DE0000 | 32'(10 + wb_seen))) begin
               $display("FAIL b2b_wb%0d: dest=%0d data=%h, need %0d/%h", wb_seen, wb_dest, wb_data,
                        10 + wb_seen, 32'hC0DE0000 | 32'(10 + wb_seen));
               errors++;
            end
            $display("b2b writeback %0d dest=%0d data=%h", wb_seen, wb_dest, wb_data);
            wb_seen++;
         end
         if (dc.cpu_dcache_request === 1'b1 && dc.cpu_dcache_write === 1'b0 && dc.cpu_dcache_address === 32'h310)
            saw5 = 1'b1;
         take = lsu_valid && lsu_ready;
         @(posedge clock); #1;
         if (take) lsu_valid = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (wb_seen != 5 || !saw5) begin
         $display("FAIL b2b_complete: writebacks=%0d fifth_issued=%b, need 5/1", wb_seen, saw5);
         errors++;
      end
      checks++;
      if (pend_count !== 5'd0) begin
         $display("FAIL b2b_drained: pend_count=%0d, need 0", pend_count); errors++;
      end
      lsu_valid   = 1'b0;
      resp_en     = 1'b0;
      tagged_data = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_stall();
      dc.cpu_dcache_ready = 1'b0;
      issue(4'b1001, 32'h402, 32'h0000BEEF, 5'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if (dc.cpu_dcache_request !== 1'b1 || dc.cpu_dcache_write !== 1'b1 || dc.cpu_dcache_address !== 32'h400 ||
             dc.cpu_dcache_wstrb !== 4'hC || dc.cpu_dcache_wdata !== 32'hBEEFBEEF || lsu_ready !== 1'b0) begin
            $display("FAIL stall%0d: req=%b write=%b addr=%h wstrb=%h wdata=%h ready=%b, need 1/1/00000400/C/BEEFBEEF/0",
                     k, dc.cpu_dcache_request, dc.cpu_dcache_write, dc.cpu_dcache_address,
                     dc.cpu_dcache_wstrb, dc.cpu_dcache_wdata, lsu_ready);
            errors++;
         end
         @(posedge clock); #1;
      end
      dc.cpu_dcache_ready = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (dc.cpu_dcache_request !== 1'b0) begin
         $display("FAIL stall_release: req=%b after ready, need 0", dc.cpu_dcache_request); errors++;
      end
      @(posedge clock); #1;
      $display("test_stall done");
   endtask

   task automatic test_reset_midop();
      issue(4'b0010, 32'h500, 32'h0, 5'd20);
      issue(4'b0010, 32'h504, 32'h0, 5'd21);
      @(negedge clock);
      checks++;
      if (pend_count !== 5'd2) begin
         $display("FAIL midop_pend: pend_count=%0d, need 2", pend_count); errors++;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (pend_count !== 5'd0 || wb_valid !== 1'b0 || dc.cpu_dcache_request !== 1'b0) begin
         $display("FAIL midop_async_reset: pend=%0d wb_valid=%b req=%b, need 0/0/0",
                  pend_count, wb_valid, dc.cpu_dcache_request);
         errors++;
      end
      @(posedge clock); @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checks++;
         if (wb_valid !== 1'b0 || pend_count !== 5'd0) begin
            $display("FAIL midop_quiet%0d: wb_valid=%b pend=%0d, need 0/0", k, wb_valid, pend_count);
            errors++;
         end
      end
      // A fresh load after reset uses slot 0 and the byte-1 lane.
      rdata_val = 32'h80FF7F01;
      resp_en   = 1'b1;
      @(posedge clock); #1;
      issue(4'b0100, 32'h201, 32'h0, 5'd9);
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b1 || wb_dest !== 5'd9 || wb_data !== 32'h0000007F) begin
         $display("FAIL midop_reload: valid=%b dest=%0d data=%h, need 1/9/0000007F", wb_valid, wb_dest, wb_data);
         errors++;
      end
      $display("test_reset_midop done");
   endtask

   initial begin
      reset     = 1'b0;
      lsu_valid = 1'b0;
      lsu_op    = 4'h0;
      lsu_addr  = 32'h0;
      lsu_wdata = 32'h0;
      lsu_dest  = 5'h0;
      dc.cpu_dcache_ready = 1'b1;
      test_reset();
      test_store_word();
      test_store_byte();
      test_loads();
      test_misaligned();
      test_back_to_back();
      test_stall();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule
